ram_arbiter: RTL and testbench

- Two-master front-end that feeds the team's single-port RAM (ports ena/we/addr/din/dout, combinational read, write on posedge clk).
- Arbitrates round-robin between master 0 (fetch) and master 1 (load/store) over a valid/ready request interface, with registered responses.
- The RAM has no byte enables, so partial writes are built here as a two-cycle read-modify-write.

---
 rtl/marvin_mem_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/marvin_mem_pkg.sv
// Shared types and helpers for the two-master RAM front-end.
// byte_merge works at a fixed maximum width; callers cast to their own width.
package marvin_mem_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_LSU   = 1'b1;

  localparam int MAX_DATA = 256;
  localparam int MAX_BE   = MAX_DATA / 8;

  // Byte lane i takes new_word when be[i] is set, otherwise keeps old_word.
  function automatic logic [MAX_DATA-1:0] byte_merge(
    input logic [MAX_DATA-1:0] old_word,
    input logic [MAX_DATA-1:0] new_word,
    input logic [MAX_BE-1:0]   be
  );
    logic [MAX_DATA-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// A grant is always taken, so every nonzero grant updates the priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_r;

  // Grant a lone requester, or on conflict the one that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (!en) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Reset value 1 lets requester 0 win the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_grant_r <= gnt[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-master front-end for a single-port RAM with combinational read.
// Partial writes are done as a read at acceptance followed by a write in RMW.
module ram_arbiter
  import marvin_mem_pkg::*;
#(
  parameter int DATA_ = 32,
  parameter int ADDR_ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req_valid,
  output logic               m0_req_ready,
  input  logic               m0_req_we,
  input  logic [DATA_/8-1:0] m0_req_be,
  input  logic [ADDR_-1:0]   m0_req_addr,
  input  logic [DATA_-1:0]   m0_req_wdata,
  output logic               m0_rsp_valid,
  output logic [DATA_-1:0]   m0_rsp_rdata,
  input  logic               m1_req_valid,
  output logic               m1_req_ready,
  input  logic               m1_req_we,
  input  logic [DATA_/8-1:0] m1_req_be,
  input  logic [ADDR_-1:0]   m1_req_addr,
  input  logic [DATA_-1:0]   m1_req_wdata,
  output logic               m1_rsp_valid,
  output logic [DATA_-1:0]   m1_rsp_rdata,
  output logic               ram_ena,
  output logic               ram_we,
  output logic [ADDR_-1:0]   ram_addr,
  output logic [DATA_-1:0]   ram_din,
  input  logic [DATA_-1:0]   ram_dout
);

  localparam int BE_W = DATA_ / 8;

  if (((DATA_ % 8) != 0) || (DATA_ > MAX_DATA)) begin : g_bad_width
    $error("ram_arbiter: DATA_ must be a multiple of 8 and at most MAX_DATA");
  end

  state_t             state_r;
  logic [1:0]         gnt_s;
  logic [1:0]         ready_s;
  logic               accept_s;
  logic               sel_s;
  logic               sel_we_s;
  logic [BE_W-1:0]    sel_be_s;
  logic [ADDR_-1:0]   sel_addr_s;
  logic [DATA_-1:0]   sel_wdata_s;
  logic               be_full_s;
  logic               be_none_s;
  logic               partial_s;
  logic [DATA_-1:0]   merged_s;
  logic [ADDR_-1:0]   rmw_addr_r;
  logic               rmw_master_r;
  logic [DATA_-1:0]   merge_r;
  logic [1:0]         rsp_valid_r;
  logic [DATA_-1:0]   rsp_rdata_r;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_r == IDLE),
    .req   ({m1_req_valid, m0_req_valid}),
    .gnt   (gnt_s)
  );

  // Ready is suppressed while reset is asserted.
  assign ready_s      = gnt_s & {2{rst_n}};
  assign accept_s     = |ready_s;
  assign sel_s        = ready_s[M_LSU];
  assign m0_req_ready = ready_s[M_FETCH];
  assign m1_req_ready = ready_s[M_LSU];

  // Route the granted master's request fields.
  always_comb begin
    if (sel_s == M_LSU) begin
      sel_we_s    = m1_req_we;
      sel_be_s    = m1_req_be;
      sel_addr_s  = m1_req_addr;
      sel_wdata_s = m1_req_wdata;
    end else begin
      sel_we_s    = m0_req_we;
      sel_be_s    = m0_req_be;
      sel_addr_s  = m0_req_addr;
      sel_wdata_s = m0_req_wdata;
    end
  end

  assign be_full_s = &sel_be_s;
  assign be_none_s = ~|sel_be_s;
  assign partial_s = sel_we_s && !be_full_s && !be_none_s;
  assign merged_s  = DATA_'(byte_merge(MAX_DATA'(ram_dout), MAX_DATA'(sel_wdata_s),
                                       MAX_BE'(sel_be_s)));

  // RAM drive: a be=0 write never enables the RAM; a partial write reads first.
  always_comb begin
    ram_ena  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = sel_addr_s;
    ram_din  = sel_wdata_s;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          ram_ena = !(sel_we_s && be_none_s);
          ram_we  = sel_we_s && be_full_s;
        end else begin
          ram_ena = 1'b0;
          ram_we  = 1'b0;
        end
      end
      RMW: begin
        ram_ena  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = rmw_addr_r;
        ram_din  = merge_r;
      end
      default: begin
        ram_ena = 1'b0;
        ram_we  = 1'b0;
      end
    endcase
  end

  // Control FSM with registered responses; reset drops any pending RMW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rmw_addr_r   <= {ADDR_{1'b0}};
      rmw_master_r <= M_FETCH;
      merge_r      <= {DATA_{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= {DATA_{1'b0}};
    end else begin
      rsp_valid_r <= 2'b00;
      case (state_r)
        IDLE: begin
          if (accept_s && partial_s) begin
            state_r      <= RMW;
            merge_r      <= merged_s;
            rmw_addr_r   <= sel_addr_s;
            rmw_master_r <= sel_s;
          end else if (accept_s) begin
            rsp_valid_r[sel_s] <= 1'b1;
            rsp_rdata_r        <= sel_we_s ? {DATA_{1'b0}} : ram_dout;
          end else begin
            state_r <= IDLE;
          end
        end
        RMW: begin
          rsp_valid_r[rmw_master_r] <= 1'b1;
          rsp_rdata_r               <= {DATA_{1'b0}};
          state_r                   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign m0_rsp_valid = rsp_valid_r[M_FETCH];
  assign m1_rsp_valid = rsp_valid_r[M_LSU];
  assign m0_rsp_rdata = rsp_rdata_r;
  assign m1_rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, a word-level shadow
// memory and a response schedule model, plus directed scenario checks.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
  logic [3:0]  m0_req_be;
  logic [7:0]  m0_req_addr;
  logic [31:0] m0_req_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
  logic [3:0]  m1_req_be;
  logic [7:0]  m1_req_addr;
  logic [31:0] m1_req_wdata, m1_rsp_rdata;
  logic        ram_ena, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic [31:0] mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] shadow [0:255];
  int          last_g;
  int          busy;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;
  int          pend_m;
  int          slot_m [0:3];
  logic [31:0] slot_d [0:3];
  int          cyc = 0;

  ram_arbiter #(.DATA_(32), .ADDR_(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_be(m0_req_be), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_be(m1_req_be), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: combinational read, write on the clock edge, bench backdoor.
  assign ram_dout = ram_ena ? mem[ram_addr] : 'x;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_ena && ram_we) mem[ram_addr] <= ram_din;
  end

  function automatic logic [31:0] preset(input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h30:    return 32'hAABBCCDD;
      'h40:    return 32'h55667788;
      default: return (32'(i) * 32'h01010101) ^ 32'hA5000000;
    endcase
  endfunction

  task automatic model_reset();
    last_g = 1;
    busy   = 0;
    for (int i = 0; i < 4; i++) begin
      slot_m[i] = -1;
      slot_d[i] = 32'h0;
    end
  endtask

  task automatic drive_idle();
    m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_be = 4'h0; m0_req_addr = 8'h00; m0_req_wdata = 32'h0;
    m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_be = 4'h0; m1_req_addr = 8'h00; m1_req_wdata = 32'h0;
  endtask

  // One clock of stimulus with model prediction and checks; returns #1 after the edge.
  task automatic step(input logic v0, input logic w0, input logic [3:0] b0, input logic [7:0] a0,
                      input logic [31:0] d0, input logic v1, input logic w1, input logic [3:0] b1,
                      input logic [7:0] a1, input logic [31:0] d1);
    int g, s, ns;
    logic w, e_r0, e_r1, e_ena, e_we, e_v0, e_v1;
    logic [3:0] b;
    logic [7:0] a;
    logic [31:0] d, nw;
    m0_req_valid = v0; m0_req_we = w0; m0_req_be = b0; m0_req_addr = a0; m0_req_wdata = d0;
    m1_req_valid = v1; m1_req_we = w1; m1_req_be = b1; m1_req_addr = a1; m1_req_wdata = d1;
    g = -1;
    if (busy == 0) begin
      if (v0 && v1) g = (last_g == 0) ? 1 : 0;
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    w = (g == 1) ? w1 : w0;
    b = (g == 1) ? b1 : b0;
    a = (g == 1) ? a1 : a0;
    d = (g == 1) ? d1 : d0;
    e_r0 = (g == 0);
    e_r1 = (g == 1);
    if (busy != 0) begin
      e_ena = 1'b1; e_we = 1'b1;
    end else if (g >= 0) begin
      e_ena = !(w && b == 4'h0); e_we = w && (b == 4'hF);
    end else begin
      e_ena = 1'b0; e_we = 1'b0;
    end
    @(negedge clk);
    s = cyc % 4;
    e_v0 = (slot_m[s] == 0);
    e_v1 = (slot_m[s] == 1);
    n_cmp += 6;
    if (m0_req_ready !== e_r0) begin n_bad++; $display("FAIL m0_ready cyc %0d: got %b want %b", cyc, m0_req_ready, e_r0); end
    if (m1_req_ready !== e_r1) begin n_bad++; $display("FAIL m1_ready cyc %0d: got %b want %b", cyc, m1_req_ready, e_r1); end
    if (ram_ena !== e_ena) begin n_bad++; $display("FAIL ram_ena cyc %0d: got %b want %b", cyc, ram_ena, e_ena); end
    if (ram_we !== e_we) begin n_bad++; $display("FAIL ram_we cyc %0d: got %b want %b", cyc, ram_we, e_we); end
    if (m0_rsp_valid !== e_v0) begin n_bad++; $display("FAIL m0_rsp_valid cyc %0d: got %b want %b", cyc, m0_rsp_valid, e_v0); end
    if (m1_rsp_valid !== e_v1) begin n_bad++; $display("FAIL m1_rsp_valid cyc %0d: got %b want %b", cyc, m1_rsp_valid, e_v1); end
    if (busy != 0) begin
      n_cmp += 2;
      if (ram_addr !== pend_addr) begin n_bad++; $display("FAIL rmw_addr cyc %0d: got %h want %h", cyc, ram_addr, pend_addr); end
      if (ram_din !== pend_data) begin n_bad++; $display("FAIL rmw_din cyc %0d: got %h want %h", cyc, ram_din, pend_data); end
    end else if (g >= 0 && e_ena) begin
      n_cmp++;
      if (ram_addr !== a) begin n_bad++; $display("FAIL ram_addr cyc %0d: got %h want %h", cyc, ram_addr, a); end
    end
    if (e_v0) begin
      n_cmp++;
      if (m0_rsp_rdata !== slot_d[s]) begin n_bad++; $display("FAIL m0_rdata cyc %0d: got %h want %h", cyc, m0_rsp_rdata, slot_d[s]); end
    end
    if (e_v1) begin
      n_cmp++;
      if (m1_rsp_rdata !== slot_d[s]) begin n_bad++; $display("FAIL m1_rdata cyc %0d: got %h want %h", cyc, m1_rsp_rdata, slot_d[s]); end
    end
    slot_m[s] = -1;
    @(posedge clk);
    #1;
    ns = (cyc + 1) % 4;
    if (busy != 0) begin
      shadow[pend_addr] = pend_data;
      busy = 0;
      slot_m[ns] = pend_m;
      slot_d[ns] = 32'h0;
    end else if (g >= 0) begin
      last_g = g;
      if (!w) begin
        slot_m[ns] = g; slot_d[ns] = shadow[a];
      end else if (b == 4'h0 || b == 4'hF) begin
        if (b == 4'hF) shadow[a] = d;
        slot_m[ns] = g; slot_d[ns] = 32'h0;
      end else begin
        nw = shadow[a];
        for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
        pend_addr = a; pend_data = nw; pend_m = g; busy = 1;
      end
    end
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  // Hold reset for n cycles with (optionally) both valids high; all outputs must be quiet.
  task automatic apply_reset(input int n, input logic hold_valid);
    rst_n = 1'b0;
    drive_idle();
    m0_req_valid = hold_valid;
    m1_req_valid = hold_valid;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_cmp += 5;
      if (m0_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_m0_ready: got %b want 0", m0_req_ready); end
      if (m1_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_m1_ready: got %b want 0", m1_req_ready); end
      if (ram_ena !== 1'b0) begin n_bad++; $display("FAIL rst_ram_ena: got %b want 0", ram_ena); end
      if (m0_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m0_rsp: got %b want 0", m0_rsp_valid); end
      if (m1_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m1_rsp: got %b want 0", m1_rsp_valid); end
      @(posedge clk);
      #1;
      cyc++;
    end
    model_reset();
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(3, 1'b1);
    n_cmp += 2;
    if (m0_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata0: got %h want 0", m0_rsp_rdata); end
    if (m1_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h want 0", m1_rsp_rdata); end
    idle_step();
    idle_step();
  endtask

  task automatic test_read_preload();
    step(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    n_cmp += 3;
    if (m0_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL preload_valid: got %b want 1", m0_rsp_valid); end
    if (m0_rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL preload_rdata: got %h want deadbeef", m0_rsp_rdata); end
    if (m1_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL preload_m1_quiet: got %b want 0", m1_rsp_valid); end
    idle_step();
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
    idle_step();
  endtask

  task automatic test_write_then_read();
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b1, 4'hF, 8'h20, 32'h12345678);
    step(1'b1, 1'b0, 4'h0, 8'h20, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    n_cmp += 2;
    if (m0_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL raw_valid: got %b want 1", m0_rsp_valid); end
    if (m0_rsp_rdata !== 32'h12345678) begin n_bad++; $display("FAIL raw_rdata: got %h want 12345678", m0_rsp_rdata); end
    idle_step();
  endtask

  task automatic test_partial();
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b1, 4'b0101, 8'h30, 32'h11223344);
    step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0, 1'b1, 1'b0, 4'h0, 8'h31, 32'h0);
    n_cmp++;
    if (m1_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rmw_ack: got %b want 1", m1_rsp_valid); end
    step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    n_cmp++;
    if (m0_rsp_rdata !== 32'hAA22CC44) begin n_bad++; $display("FAIL rmw_merge: got %h want aa22cc44", m0_rsp_rdata); end
    idle_step();
  endtask

  task automatic test_be_zero();
    step(1'b1, 1'b1, 4'h0, 8'h30, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    n_cmp += 2;
    if (m0_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL be0_ack: got %b want 1", m0_rsp_valid); end
    if (m0_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL be0_rdata: got %h want 0", m0_rsp_rdata); end
    step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    n_cmp++;
    if (m0_rsp_rdata !== 32'hAA22CC44) begin n_bad++; $display("FAIL be0_unchanged: got %h want aa22cc44", m0_rsp_rdata); end
    idle_step();
  endtask

  task automatic test_rmw_reset();
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b1, 4'b0011, 8'h40, 32'h0);
    apply_reset(2, 1'b1);
    n_cmp++;
    if (mem[8'h40] !== 32'h55667788) begin n_bad++; $display("FAIL rmw_drop: got %h want 55667788", mem[8'h40]); end
    m0_req_valid = 1'b1; m0_req_addr = 8'h01;
    m1_req_valid = 1'b1; m1_req_addr = 8'h02;
    #1;
    n_cmp += 2;
    if (m0_req_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_m0_wins: got %b want 1", m0_req_ready); end
    if (m1_req_ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_m1_waits: got %b want 0", m1_req_ready); end
    step(1'b1, 1'b0, 4'h0, 8'h01, 32'h0, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
    idle_step();
  endtask

  task automatic test_random();
    logic v0, v1, w0, w1;
    logic [3:0] b0, b1;
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      r = $urandom;
      b0 = (r[1:0] == 2'd0) ? 4'h0 : (r[1:0] == 2'd1) ? 4'hF : r[7:4];
      b1 = (r[9:8] == 2'd0) ? 4'h0 : (r[9:8] == 2'd1) ? 4'hF : r[15:12];
      step(v0, w0, b0, 8'($urandom_range(0, 15)), $urandom,
           v1, w1, b1, 8'($urandom_range(0, 15)), $urandom);
    end
    idle_step();
    idle_step();
  endtask

  task automatic test_final_memory();
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (mem[i] !== shadow[i]) begin n_bad++; $display("FAIL mem[%0d]: got %h want %h", i, mem[i], shadow[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    bd_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bd_addr = 8'(i);
      bd_data = preset(i);
      shadow[i] = preset(i);
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;
    test_reset();
    test_read_preload();
    test_alternate();
    test_write_then_read();
    test_partial();
    test_be_zero();
    test_rmw_reset();
    test_random();
    test_final_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
